// File: rtl/rom_fetch_ctrl.sv
// Fetch controller in front of a 4096x16 synchronous ROM: window decode, demand reads
// with one-cycle ROM latency, and a one-word sequential prefetch buffer.
module rom_fetch_ctrl #(
  parameter logic [2:0] ROM_BASE = 3'b000,
  parameter bit         PREFETCH = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  output logic        cpu_busy,
  output logic        cpu_ready,
  output logic [15:0] cpu_data,
  output logic        pf_hit,
  output logic        rom_ncs,
  output logic [11:0] rom_addr,
  input  logic [15:0] rom_do
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] D_ISSUE = 3'd1;
  localparam logic [2:0] D_WAIT  = 3'd2;
  localparam logic [2:0] P_ISSUE = 3'd3;
  localparam logic [2:0] P_WAIT  = 3'd4;

  logic [2:0]  state;
  logic        pf_valid;
  logic [11:0] pf_addr;
  logic [15:0] pf_data;
  logic        pend_v;
  logic [11:0] pend_a;

  logic        acc_rd;
  logic        acc_wr;
  logic [11:0] wa;
  logic        eff_v;
  logic [11:0] eff_a;
  logic [11:0] base_a;
  logic        pf_go;
  logic        addr_lsb_unused;

  assign addr_lsb_unused = cpu_addr[0];

  always_comb begin
    wa     = cpu_addr[12:1];
    acc_rd = cpu_req && !cpu_busy && (cpu_addr[15:13] == ROM_BASE) && !cpu_we;
    acc_wr = cpu_req && !cpu_busy && (cpu_addr[15:13] == ROM_BASE) && cpu_we;
    // A read strobed on the P_WAIT edge itself is resolved together with a latched one.
    eff_v  = pend_v || acc_rd;
    eff_a  = pend_v ? pend_a : wa;
    // rom_addr still holds the demand word in D_WAIT, since it only moves with rom_ncs=0.
    base_a = wa;
    if (state == D_WAIT)      base_a = rom_addr;
    else if (state == P_WAIT) base_a = eff_a;
    pf_go  = PREFETCH && (base_a != '1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      rom_ncs   <= 1'b1;
      rom_addr  <= '0;
      cpu_ready <= 1'b0;
      cpu_busy  <= 1'b0;
      cpu_data  <= '0;
      pf_hit    <= 1'b0;
      pf_valid  <= 1'b0;
      pf_addr   <= '0;
      pf_data   <= '0;
      pend_v    <= 1'b0;
      pend_a    <= '0;
    end else begin
      cpu_ready <= 1'b0;
      pf_hit    <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_wr) begin
            cpu_ready <= 1'b1;
          end else if (acc_rd) begin
            if (pf_valid && wa == pf_addr) begin
              cpu_data  <= pf_data;
              cpu_ready <= 1'b1;
              pf_hit    <= 1'b1;
              pf_valid  <= 1'b0;
              if (pf_go) begin
                rom_ncs  <= 1'b0;
                rom_addr <= base_a + 12'd1;
                pf_addr  <= base_a + 12'd1;
                state    <= P_ISSUE;
              end else begin
                state <= IDLE;
              end
            end else begin
              rom_ncs  <= 1'b0;
              rom_addr <= wa;
              cpu_busy <= 1'b1;
              pf_valid <= 1'b0;
              state    <= D_ISSUE;
            end
          end
        end
        D_ISSUE: begin
          rom_ncs <= 1'b1;
          state   <= D_WAIT;
        end
        D_WAIT: begin
          cpu_data  <= rom_do;
          cpu_ready <= 1'b1;
          cpu_busy  <= 1'b0;
          if (pf_go) begin
            rom_ncs  <= 1'b0;
            rom_addr <= base_a + 12'd1;
            pf_addr  <= base_a + 12'd1;
            state    <= P_ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        P_ISSUE: begin
          rom_ncs <= 1'b1;
          state   <= P_WAIT;
          if (acc_wr && !pend_v) cpu_ready <= 1'b1;
          if (acc_rd && !pend_v) begin
            pend_v <= 1'b1;
            pend_a <= wa;
          end
        end
        P_WAIT: begin
          pend_v <= 1'b0;
          if (acc_wr && !pend_v) cpu_ready <= 1'b1;
          if (eff_v && eff_a == pf_addr) begin
            cpu_data  <= rom_do;
            cpu_ready <= 1'b1;
            pf_hit    <= 1'b1;
            pf_valid  <= 1'b0;
            if (pf_go) begin
              rom_ncs  <= 1'b0;
              rom_addr <= base_a + 12'd1;
              pf_addr  <= base_a + 12'd1;
              state    <= P_ISSUE;
            end else begin
              state <= IDLE;
            end
          end else if (eff_v) begin
            rom_ncs  <= 1'b0;
            rom_addr <= eff_a;
            cpu_busy <= 1'b1;
            pf_valid <= 1'b0;
            state    <= D_ISSUE;
          end else begin
            pf_data  <= rom_do;
            pf_valid <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
